// File: rtl/if_fetch.sv
// Instruction fetch front end: one outstanding memory request,
// a small {pc, inst} FIFO toward decode, and redirect handling.
module if_fetch #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int unsigned DEPTH    = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        jCe,
   input  logic [31:0] jAddr,
   output logic        imReq,
   output logic [31:0] imAddr,
   input  logic        imAck,
   input  logic [31:0] imData,
   input  logic        idReady,
   output logic        instValid,
   output logic [31:0] pc,
   output logic [31:0] inst
);
   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;
   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT,
      S_SQUASH
   } state_t;

   state_t        r_state;
   logic          r_req;
   logic [31:0]   r_addr;
   logic [31:0]   r_fpc;
   logic [CW-1:0] r_count;
   logic [AW-1:0] r_wp;
   logic [AW-1:0] r_rp;
   logic [31:0]   r_qa [DEPTH];
   logic [31:0]   r_qd [DEPTH];

   logic          w_pop;
   logic          w_push;
   logic          w_room;
   logic [CW-1:0] w_cnt;
   logic [31:0]   w_tgt;
   logic [31:0]   w_inc;

   assign instValid = (r_count != '0);
   assign pc        = instValid ? r_qa[r_rp] : '0;
   assign inst      = instValid ? r_qd[r_rp] : '0;
   assign imReq     = r_req;
   assign imAddr    = r_addr;

   assign w_pop  = instValid && idReady && !jCe;
   assign w_push = (r_state == S_WAIT) && imAck && !jCe;
   assign w_tgt  = {jAddr[31:2], 2'b00};
   assign w_inc  = r_fpc + 32'd4;
   // The in-flight request reserves a slot, so a new fetch needs
   // the post-push/pop occupancy to stay below DEPTH.
   assign w_cnt  = r_count + CW'(w_push) - CW'(w_pop);
   assign w_room = (w_cnt < FULL);

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_qa[r_wp] <= r_addr;
         r_qd[r_wp] <= imData;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= S_IDLE;
         r_req   <= 1'b0;
         r_addr  <= '0;
         r_fpc   <= RESET_PC;
         r_count <= '0;
         r_wp    <= '0;
         r_rp    <= '0;
      end else begin
         if (jCe) begin
            r_count <= '0;
            r_wp    <= '0;
            r_rp    <= '0;
         end else begin
            r_count <= w_cnt;
            if (w_push) r_wp <= r_wp + 1'b1;
            if (w_pop)  r_rp <= r_rp + 1'b1;
         end

         unique case (r_state)
            S_IDLE: begin
               if (jCe) begin
                  r_fpc <= w_tgt;
               end else if (w_room) begin
                  r_state <= S_WAIT;
                  r_req   <= 1'b1;
                  r_addr  <= r_fpc;
               end
            end
            S_WAIT: begin
               if (jCe) begin
                  r_fpc <= w_tgt;
                  if (imAck) begin
                     r_state <= S_IDLE;
                     r_req   <= 1'b0;
                  end else begin
                     r_state <= S_SQUASH;
                  end
               end else if (imAck) begin
                  r_fpc <= w_inc;
                  if (w_room) begin
                     r_addr <= w_inc;
                  end else begin
                     r_state <= S_IDLE;
                     r_req   <= 1'b0;
                  end
               end
            end
            S_SQUASH: begin
               if (jCe) r_fpc <= w_tgt;
               if (imAck) begin
                  r_state <= S_IDLE;
                  r_req   <= 1'b0;
               end
            end
            default: begin
               r_state <= S_IDLE;
               r_req   <= 1'b0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_if_fetch.sv
// Bench for if_fetch: directed scenarios plus random traffic
// checked against a queue-based fetch model.
module tb_if_fetch;
   localparam int unsigned DEPTH = 2;
   localparam logic [31:0] RPC = 32'h0000_0100;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        jCe = 1'b0;
   logic [31:0] jAddr = '0;
   logic        imAck = 1'b0;
   logic [31:0] imData = '0;
   logic        idReady = 1'b0;
   logic        imReq;
   logic [31:0] imAddr;
   logic        instValid;
   logic [31:0] pc;
   logic [31:0] inst;

   int n_chk = 0;
   int n_err = 0;

   typedef struct {
      logic [31:0] a;
      logic [31:0] d;
   } ent_t;

   ent_t        m_q[$];
   logic [31:0] m_fpc;
   logic [31:0] m_oaddr;
   logic        m_out;
   logic        m_stale;

   always #5 clk = ~clk;

   if_fetch #(
      .RESET_PC(RPC),
      .DEPTH   (DEPTH)
   ) u_dut (
      .clk      (clk),
      .rst      (rst),
      .jCe      (jCe),
      .jAddr    (jAddr),
      .imReq    (imReq),
      .imAddr   (imAddr),
      .imAck    (imAck),
      .imData   (imData),
      .idReady  (idReady),
      .instValid(instValid),
      .pc       (pc),
      .inst     (inst)
   );

   function automatic logic [31:0] memw(input logic [31:0] a);
      return {a[15:0], ~a[31:16]} ^ 32'h5A5A_C3C3;
   endfunction

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got %h exp %h", tag, got, exp);
      end
   endtask

   task automatic mdl_reset();
      m_q.delete();
      m_fpc   = RPC;
      m_oaddr = '0;
      m_out   = 1'b0;
      m_stale = 1'b0;
   endtask

   task automatic mdl_step(input logic j, input logic [31:0] ja,
                           input logic ack, input logic rdy,
                           input logic [31:0] d);
      logic was;
      logic pop;
      was = m_out;
      pop = (m_q.size() != 0) && rdy && !j;
      if (j) m_q.delete();
      else if (pop) void'(m_q.pop_front());
      if (was && ack) begin
         if (!m_stale && !j) begin
            m_q.push_back('{a: m_oaddr, d: d});
            m_fpc = m_fpc + 32'd4;
            if (m_q.size() < DEPTH) m_oaddr = m_fpc;
            else m_out = 1'b0;
         end else begin
            m_out = 1'b0;
         end
         m_stale = 1'b0;
      end else if (was && j) begin
         m_stale = 1'b1;
      end
      if (j) m_fpc = {ja[31:2], 2'b00};
      if (!was && !j && m_q.size() < DEPTH) begin
         m_out   = 1'b1;
         m_oaddr = m_fpc;
      end
   endtask

   task automatic cmp_all();
      logic [31:0] epc;
      logic [31:0] ein;
      epc = '0;
      ein = '0;
      if (m_q.size() != 0) begin
         epc = m_q[0].a;
         ein = m_q[0].d;
      end
      chk("imReq", 32'(imReq), 32'(m_out));
      chk("imAddr", imAddr, m_oaddr);
      chk("instValid", 32'(instValid), 32'(m_q.size() != 0));
      chk("pc", pc, epc);
      chk("inst", inst, ein);
   endtask

   task automatic step(input logic j, input logic [31:0] ja,
                       input logic ack, input logic rdy);
      jCe     = j;
      jAddr   = ja;
      imAck   = ack;
      idReady = rdy;
      imData  = (m_out && ack) ? memw(m_oaddr) : $urandom;
      @(posedge clk);
      mdl_step(j, ja, ack, rdy, imData);
      #1;
      cmp_all();
   endtask

   task automatic do_reset();
      rst = 1'b0;
      mdl_reset();
      #1;
      cmp_all();
      @(posedge clk);
      #3;
      rst = 1'b1;
   endtask

   initial begin
      #1;
      rst = 1'b0;
      mdl_reset();
      #1;
      cmp_all();
      @(posedge clk);
      #3;
      rst = 1'b1;

      // streaming fetch, one per cycle
      step(1'b0, '0, 1'b1, 1'b1);
      chk("s1_addr", imAddr, 32'h100);
      step(1'b0, '0, 1'b1, 1'b1);
      chk("s2_addr", imAddr, 32'h104);
      chk("s2_pc", pc, 32'h100);
      step(1'b0, '0, 1'b1, 1'b1);
      chk("s3_addr", imAddr, 32'h108);
      chk("s3_pc", pc, 32'h104);
      chk("s3_vld", 32'(instValid), 32'd1);

      // back-pressure fills DEPTH entries then stalls
      do_reset();
      for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b1, 1'b0);
      chk("bp_req", 32'(imReq), 32'd0);
      chk("bp_pc", pc, 32'h100);
      step(1'b0, '0, 1'b1, 1'b1);
      chk("bp_pc2", pc, 32'h104);
      chk("bp_addr", imAddr, 32'h108);
      chk("bp_req2", 32'(imReq), 32'd1);

      // redirect from IDLE with a full FIFO
      do_reset();
      for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b1, 1'b0);
      step(1'b1, 32'h2003, 1'b1, 1'b1);
      chk("rd_vld", 32'(instValid), 32'd0);
      step(1'b0, '0, 1'b1, 1'b1);
      chk("rd_addr", imAddr, 32'h2000);
      step(1'b0, '0, 1'b1, 1'b1);
      chk("rd_pc", pc, 32'h2000);

      // redirect in WAIT with a late ack
      do_reset();
      step(1'b0, '0, 1'b0, 1'b1);
      step(1'b1, 32'h3000, 1'b0, 1'b1);
      step(1'b0, '0, 1'b0, 1'b1);
      step(1'b0, '0, 1'b0, 1'b1);
      step(1'b0, '0, 1'b1, 1'b1);
      chk("sq_req", 32'(imReq), 32'd0);
      chk("sq_vld", 32'(instValid), 32'd0);
      step(1'b0, '0, 1'b1, 1'b1);
      chk("sq_addr", imAddr, 32'h3000);
      step(1'b0, '0, 1'b1, 1'b1);
      chk("sq_pc", pc, 32'h3000);

      // redirect together with ack
      do_reset();
      step(1'b0, '0, 1'b0, 1'b1);
      step(1'b1, 32'h4000, 1'b1, 1'b1);
      chk("ja_req", 32'(imReq), 32'd0);
      step(1'b0, '0, 1'b1, 1'b1);
      chk("ja_addr", imAddr, 32'h4000);

      // fetch address wraps past the top of memory
      do_reset();
      step(1'b1, 32'hFFFF_FFFF, 1'b0, 1'b1);
      step(1'b0, '0, 1'b1, 1'b1);
      chk("wr_addr0", imAddr, 32'hFFFF_FFFC);
      step(1'b0, '0, 1'b1, 1'b1);
      chk("wr_addr1", imAddr, 32'h0000_0000);
      chk("wr_pc0", pc, 32'hFFFF_FFFC);
      step(1'b0, '0, 1'b1, 1'b1);
      chk("wr_pc1", pc, 32'h0000_0000);

      // async reset while squashing
      do_reset();
      step(1'b0, '0, 1'b0, 1'b1);
      step(1'b1, 32'h5000, 1'b0, 1'b1);
      #2;
      do_reset();
      chk("ar_req", 32'(imReq), 32'd0);
      step(1'b0, '0, 1'b1, 1'b1);
      chk("ar_addr", imAddr, RPC);
      step(1'b0, '0, 1'b1, 1'b1);
      chk("ar_pc", pc, RPC);

      // random traffic
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         logic        j;
         logic        a;
         logic        r;
         logic [31:0] t;
         j = ($urandom_range(0, 7) == 0);
         a = ($urandom_range(0, 1) == 1);
         r = ($urandom_range(0, 2) != 0);
         t = $urandom;
         if ($urandom_range(0, 9) == 0) t = t | 32'hFFFF_FFF0;
         if ($urandom_range(0, 299) == 0) do_reset();
         else step(j, t, a, r);
      end

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end
endmodule
